// File: rtl/rot_edn_stub_pkg.sv
// Shared types and constants for the EDN entropy responder stub.
package rot_edn_stub_pkg;

    // Responder state machine encoding.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2
    } edn_stub_state_e;

    // Feedback taps of the 32-bit Fibonacci LFSR: bits 31, 21, 1 and 0.
    localparam logic [31:0] LfsrTapMask = 32'h8020_0003;

    // Seed used at reset and whenever a zero seed is requested.
    localparam logic [31:0] LfsrDefaultSeed = 32'hACE1_2468;

    // One left-shift step of the LFSR; feedback is the XOR of the tapped bits.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], ^(s & LfsrTapMask)};
    endfunction

endpackage

// File: rtl/rot_edn_lfsr.sv
// 32-bit Fibonacci LFSR with advance strobe and zero-guarded seed load.
module rot_edn_lfsr
    import rot_edn_stub_pkg::*;
#(
    parameter logic [31:0] Seed = LfsrDefaultSeed
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        advance_i,
    output logic [31:0] state_o
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    // Next state: a load wins over an advance; a zero seed would lock up, so it maps to Seed.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == 32'h0000_0000) ? Seed : seed_i;
        end else if (advance_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register with synchronous reset to the seed.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr_q <= Seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/rot_edn_stub.sv
// EDN responder: answers each request with a one-cycle ack carrying an LFSR word
// after a programmable latency. All outputs come straight from registers.
module rot_edn_stub
    import rot_edn_stub_pkg::*;
#(
    parameter logic [31:0] LfsrSeed   = LfsrDefaultSeed,
    parameter int unsigned AckLatency = 32'd4,
    parameter logic        FipsFlag   = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        edn_req_i,
    input  logic        seed_load_i,
    input  logic [31:0] seed_i,
    output logic        edn_ack_o,
    output logic        edn_fips_o,
    output logic [31:0] edn_bus_o,
    output logic [15:0] word_cnt_o,
    output logic        busy_o
);

    // Counter preload; the Wait state leaves for Ack when the counter is at 1,
    // which puts the ack AckLatency cycles after acceptance.
    localparam logic [7:0] LatLoad = 8'(AckLatency - 32'd1);

    edn_stub_state_e state_q, state_d;
    logic [7:0]      lat_cnt_q, lat_cnt_d;
    logic            ack_q, ack_d;
    logic            fips_q, fips_d;
    logic [31:0]     bus_q, bus_d;
    logic [15:0]     word_cnt_q, word_cnt_d;
    logic            busy_q, busy_d;
    logic            lfsr_load_s;
    logic            lfsr_adv_s;
    logic [31:0]     lfsr_state_s;

    rot_edn_lfsr #(
        .Seed (LfsrSeed)
    ) u_lfsr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (lfsr_load_s),
        .seed_i    (seed_i),
        .advance_i (lfsr_adv_s),
        .state_o   (lfsr_state_s)
    );

    // Next-state logic: acceptance, latency countdown, abort and word delivery.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        lfsr_load_s = 1'b0;
        lfsr_adv_s  = 1'b0;
        case (state_q)
            StIdle: begin
                lfsr_load_s = seed_load_i;
                if (enable_i && edn_req_i) begin
                    if (AckLatency == 32'd1) begin
                        state_d    = StAck;
                        lfsr_adv_s = 1'b1;
                    end else begin
                        state_d   = StWait;
                        lat_cnt_d = LatLoad;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (!(enable_i && edn_req_i)) begin
                    state_d   = StIdle;
                    lat_cnt_d = 8'd0;
                end else if (lat_cnt_q == 8'd1) begin
                    state_d    = StAck;
                    lat_cnt_d  = 8'd0;
                    lfsr_adv_s = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - 8'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d   = StIdle;
                lat_cnt_d = 8'd0;
            end
        endcase
    end

    // Output next values: the word is captured on the edge entering Ack, as the LFSR advances.
    always_comb begin
        ack_d      = (state_d == StAck);
        fips_d     = (state_d == StAck) ? FipsFlag : 1'b0;
        busy_d     = (state_d != StIdle);
        bus_d      = bus_q;
        word_cnt_d = word_cnt_q;
        if (lfsr_adv_s) begin
            bus_d = lfsr_state_s;
            if (word_cnt_q != 16'hFFFF) begin
                word_cnt_d = word_cnt_q + 16'd1;
            end else begin
                word_cnt_d = word_cnt_q;
            end
        end else begin
            bus_d = bus_q;
        end
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            lat_cnt_q  <= 8'd0;
            ack_q      <= 1'b0;
            fips_q     <= 1'b0;
            bus_q      <= 32'h0000_0000;
            word_cnt_q <= 16'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            ack_q      <= ack_d;
            fips_q     <= fips_d;
            bus_q      <= bus_d;
            word_cnt_q <= word_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign edn_ack_o  = ack_q;
    assign edn_fips_o = fips_q;
    assign edn_bus_o  = bus_q;
    assign word_cnt_o = word_cnt_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_rot_edn_stub.sv
// Scoreboard bench for rot_edn_stub: instance A uses latency 4 / FIPS 0,
// instance B uses latency 1 / FIPS 1.
module tb_rot_edn_stub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, req_a, sl_a;
    logic [31:0] seed_a;
    logic        ack_a, fips_a, busy_a;
    logic [31:0] bus_a;
    logic [15:0] cnt_a;
    logic        en_b, req_b, sl_b;
    logic [31:0] seed_b;
    logic        ack_b, fips_b, busy_b;
    logic [31:0] bus_b;
    logic [15:0] cnt_b;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];
    logic [31:0] m_a;
    logic [31:0] m_b;
    int          n;

    always #5 clk = ~clk;

    rot_edn_stub u_a (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en_a), .edn_req_i(req_a),
        .seed_load_i(sl_a), .seed_i(seed_a), .edn_ack_o(ack_a), .edn_fips_o(fips_a),
        .edn_bus_o(bus_a), .word_cnt_o(cnt_a), .busy_o(busy_a)
    );

    rot_edn_stub #(.AckLatency(32'd1), .FipsFlag(1'b1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en_b), .edn_req_i(req_b),
        .seed_load_i(sl_b), .seed_i(seed_b), .edn_ack_o(ack_b), .edn_fips_o(fips_b),
        .edn_bus_o(bus_b), .word_cnt_o(cnt_b), .busy_o(busy_b)
    );

    // Count a comparison and report it when observed differs from expected.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference LFSR step.
    function automatic logic [31:0] ref_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait for the next ack on instance A (b=0) or B (b=1); pop the scoreboard and compare.
    task automatic wait_ack(input bit b, input int max, output int cycles);
        logic [31:0] e;
        cycles = 0;
        for (int i = 0; i < max; i++) begin
            tick();
            sl_a = 1'b0;
            sl_b = 1'b0;
            cycles++;
            if (b ? ack_b : ack_a) begin
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("bus", b ? bus_b : bus_a, e);
                end
                chk("fips_ack", {31'd0, b ? fips_b : fips_a}, {31'd0, b});
                return;
            end
            chk("fips_noack", {31'd0, b ? fips_b : fips_a}, 32'd0);
        end
        chk("ack_timeout", 32'd0, 32'd1);
        cycles = -1;
    endtask

    initial begin
        rst_n = 1'b0;
        en_a = 1'b1; req_a = 1'b0; sl_a = 1'b0; seed_a = 32'd0;
        en_b = 1'b0; req_b = 1'b0; sl_b = 1'b0; seed_b = 32'd0;
        m_a = 32'hACE1_2468;
        m_b = 32'hACE1_2468;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_ack_a", {31'd0, ack_a}, 32'd0);
        chk("rst_fips_a", {31'd0, fips_a}, 32'd0);
        chk("rst_bus_a", bus_a, 32'd0);
        chk("rst_cnt_a", {16'd0, cnt_a}, 32'd0);
        chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
        chk("rst_bus_b", bus_b, 32'd0);

        // Instance B: disabled requests are never accepted.
        req_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("dis_ack_b", {31'd0, ack_b}, 32'd0);
            chk("dis_busy_b", {31'd0, busy_b}, 32'd0);
        end
        // Latency 1: ack one cycle after acceptance, then one Idle cycle between acks.
        en_b = 1'b1;
        sb_q.push_back(m_b); m_b = ref_next(m_b);
        wait_ack(1'b1, 10, n);
        chk("lat_b", n, 32'd1);
        tick();
        chk("gap_ack_b", {31'd0, ack_b}, 32'd0);
        chk("gap_fips_b", {31'd0, fips_b}, 32'd0);
        sb_q.push_back(m_b); m_b = ref_next(m_b);
        wait_ack(1'b1, 10, n);
        chk("lat_b2", n, 32'd1);
        chk("cnt_b", {16'd0, cnt_b}, 32'd2);
        req_b = 1'b0; en_b = 1'b0;
        tick();

        // T1: seed 1 with request; one ack after 4 cycles.
        sl_a = 1'b1; seed_a = 32'd1; req_a = 1'b1;
        m_a = 32'd1;
        sb_q.push_back(m_a); m_a = ref_next(m_a);
        wait_ack(1'b0, 20, n);
        chk("lat_a", n, 32'd4);
        chk("cnt_a1", {16'd0, cnt_a}, 32'd1);
        req_a = 1'b0;
        tick();
        chk("idle_busy_a", {31'd0, busy_a}, 32'd0);
        chk("bus_hold_a", bus_a, 32'd1);

        // T2: held request, acks every 5 cycles: 1, 3, 6.
        sl_a = 1'b1; seed_a = 32'd1; req_a = 1'b1;
        m_a = 32'd1;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(m_a); m_a = ref_next(m_a);
        end
        chk("model_seq", sb_q[2], 32'd6);
        wait_ack(1'b0, 20, n);
        chk("lat_a_first", n, 32'd4);
        wait_ack(1'b0, 20, n);
        chk("spacing_a1", n, 32'd5);
        wait_ack(1'b0, 20, n);
        chk("spacing_a2", n, 32'd5);
        req_a = 1'b0;
        tick();
        chk("cnt_a4", {16'd0, cnt_a}, 32'd4);

        // T3: abort after 2 Wait cycles; next word is the one the abort would have had.
        req_a = 1'b1;
        tick();
        chk("abort_busy", {31'd0, busy_a}, 32'd1);
        tick();
        tick();
        chk("abort_noack", {31'd0, ack_a}, 32'd0);
        req_a = 1'b0;
        tick();
        chk("abort_idle", {31'd0, busy_a}, 32'd0);
        chk("abort_noack2", {31'd0, ack_a}, 32'd0);
        req_a = 1'b1;
        sb_q.push_back(m_a); m_a = ref_next(m_a);
        wait_ack(1'b0, 20, n);
        chk("lat_after_abort", n, 32'd4);
        req_a = 1'b0;
        tick();

        // T4: zero seed maps to the default; seed load during Wait is ignored.
        sl_a = 1'b1; seed_a = 32'd0; req_a = 1'b1;
        m_a = 32'hACE1_2468;
        sb_q.push_back(m_a); m_a = ref_next(m_a);
        wait_ack(1'b0, 20, n);
        req_a = 1'b0;
        tick();
        req_a = 1'b1;
        tick();
        sl_a = 1'b1; seed_a = 32'd5;
        sb_q.push_back(m_a); m_a = ref_next(m_a);
        wait_ack(1'b0, 20, n);
        chk("lat_wait_seed", n, 32'd3);
        req_a = 1'b0;
        tick();

        // T5: reset on the ack cycle clears everything.
        req_a = 1'b1;
        sb_q.push_back(m_a); m_a = ref_next(m_a);
        wait_ack(1'b0, 20, n);
        rst_n = 1'b0; req_a = 1'b0;
        tick();
        chk("rr_ack", {31'd0, ack_a}, 32'd0);
        chk("rr_fips", {31'd0, fips_a}, 32'd0);
        chk("rr_bus", bus_a, 32'd0);
        chk("rr_cnt", {16'd0, cnt_a}, 32'd0);
        chk("rr_busy", {31'd0, busy_a}, 32'd0);
        rst_n = 1'b1;
        m_a = 32'hACE1_2468;
        tick();
        req_a = 1'b1;
        sb_q.push_back(m_a); m_a = ref_next(m_a);
        wait_ack(1'b0, 20, n);
        chk("lat_post_rst", n, 32'd4);
        req_a = 1'b0;
        tick();

        // T6: word counter saturates at 16'hFFFF.
        force u_a.word_cnt_q = 16'hFFFF;
        tick();
        release u_a.word_cnt_q;
        tick();
        chk("cnt_forced", {16'd0, cnt_a}, 32'h0000_FFFF);
        req_a = 1'b1;
        sb_q.push_back(m_a); m_a = ref_next(m_a);
        wait_ack(1'b0, 20, n);
        chk("cnt_sat", {16'd0, cnt_a}, 32'h0000_FFFF);
        req_a = 1'b0;
        tick();
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
